// File: rtl/addsub_accumulator_nbit_if.sv
// Operation and result bundle for the n-bit add/subtract accumulator.
// The master drives requests and observes results; the slave is the accumulator.
interface addsub_accumulator_nbit_if #(
    parameter int n = 4
);
    logic         in_valid;
    logic [n-1:0] x;
    logic [1:0]   op;
    logic         is_signed;
    logic         sat_en;

    logic [n-1:0] acc;
    logic         out_valid;
    logic         c_out;
    logic         overflow;
    logic         ovf_sticky;
    logic [n-1:0] op_count;

    modport master (
        output in_valid, x, op, is_signed, sat_en,
        input  acc, out_valid, c_out, overflow, ovf_sticky, op_count
    );

    modport slave (
        input  in_valid, x, op, is_signed, sat_en,
        output acc, out_valid, c_out, overflow, ovf_sticky, op_count
    );
endinterface

// File: rtl/addsub_accumulator_nbit.sv
// Two-stage n-bit add/subtract accumulator with load/clear, signed or
// unsigned saturation, carry/overflow flags, sticky overflow and a
// saturating count of arithmetic operations since the last load/clear.
// Stage 1 registers the request; stage 2 executes it against acc. Only
// stage 2 writes acc, so back-to-back operations chain with no forwarding.
module addsub_accumulator_nbit #(
    parameter int n = 4
) (
    input  logic clk,
    input  logic rst,
    addsub_accumulator_nbit_if.slave bus
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [n-1:0] SIGNED_MAX = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0] SIGNED_MIN = {1'b1, {(n-1){1'b0}}};
    localparam logic [n-1:0] COUNT_ONE  = {{(n-1){1'b0}}, 1'b1};

    // Stage-1 request registers
    logic         s1_valid;
    logic [n-1:0] s1_x;
    logic [1:0]   s1_op;
    logic         s1_signed;
    logic         s1_sat;

    // Architectural state
    logic [n-1:0] acc_q;
    logic         out_valid_q;
    logic         c_out_q;
    logic         overflow_q;
    logic         ovf_sticky_q;
    logic [n-1:0] op_count_q;

    // Execute-stage combinational results
    logic         is_sub;
    logic [n-1:0] eff_x;
    logic [n:0]   sum;
    logic         signed_ovf;
    logic         unsigned_ovf;
    logic         arith_ovf;
    logic [n-1:0] arith_result;

    // Capture the request and its mode bits; reset drops any pending request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_op     <= OP_ADD;
            s1_signed <= 1'b0;
            s1_sat    <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x      <= bus.x;
                s1_op     <= bus.op;
                s1_signed <= bus.is_signed;
                s1_sat    <= bus.sat_en;
            end
        end
    end

    // Adder core, overflow detection and saturation select for add/subtract
    always_comb begin
        is_sub       = (s1_op == OP_SUB);
        eff_x        = is_sub ? ~s1_x : s1_x;
        sum          = {1'b0, acc_q} + {1'b0, eff_x} + {{n{1'b0}}, is_sub};
        signed_ovf   = (acc_q[n-1] == eff_x[n-1]) && (sum[n-1] != acc_q[n-1]);
        unsigned_ovf = is_sub ? ~sum[n] : sum[n];
        arith_ovf    = s1_signed ? signed_ovf : unsigned_ovf;
        arith_result = sum[n-1:0];
        if (s1_sat && arith_ovf) begin
            if (s1_signed) begin
                arith_result = acc_q[n-1] ? SIGNED_MIN : SIGNED_MAX;
            end else begin
                arith_result = is_sub ? '0 : '1;
            end
        end
    end

    // Execute the registered request and update accumulator, flags and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            c_out_q      <= 1'b0;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                case (s1_op)
                    OP_LOAD: begin
                        acc_q      <= s1_x;
                        c_out_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        op_count_q <= '0;
                    end
                    OP_CLEAR: begin
                        acc_q        <= '0;
                        c_out_q      <= 1'b0;
                        overflow_q   <= 1'b0;
                        ovf_sticky_q <= 1'b0;
                        op_count_q   <= '0;
                    end
                    default: begin
                        acc_q        <= arith_result;
                        c_out_q      <= sum[n];
                        overflow_q   <= arith_ovf;
                        ovf_sticky_q <= ovf_sticky_q | arith_ovf;
                        if (!(&op_count_q)) begin
                            op_count_q <= op_count_q + COUNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.acc        = acc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.c_out      = c_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_accumulator_nbit.sv
// Directed bench for addsub_accumulator_nbit at n=4. Status is compared as
// {out_valid, acc, c_out, overflow, ovf_sticky, op_count} against
// hand-computed values.
module tb_addsub_accumulator_nbit;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] LD  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    addsub_accumulator_nbit_if #(.n(4)) bus ();

    addsub_accumulator_nbit #(.n(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] status;
    assign status = {bus.out_valid, bus.acc, bus.c_out, bus.overflow,
                     bus.ovf_sticky, bus.op_count};

    // Issue one request, then scramble the inputs while in_valid is low;
    // returns at the negedge where the result is visible.
    task automatic do_op(input logic [1:0] o, input logic [3:0] v,
                         input logic s, input logic sat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = v; bus.op = o;
        bus.is_signed = s; bus.sat_en = sat;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.x = ~v; bus.op = CLR;
        bus.is_signed = ~s; bus.sat_en = ~sat;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.x = 4'h0; bus.op = ADD;
        bus.is_signed = 1'b0; bus.sat_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (status !== 12'h000) begin
            errors++; $display("[TB] FAIL reset_state got %h want %h", status, 12'h000);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_unsigned();
        do_op(LD, 4'h5, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++; $display("[TB] FAIL load5 got %h want %h", status, {1'b1, 4'h5, 7'd0});
        end
        do_op(ADD, 4'h6, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            errors++; $display("[TB] FAIL add_u got %h want %h", status, {1'b1, 4'hB, 3'b000, 4'd1});
        end
    endtask

    task automatic test_add_signed();
        do_op(CLR, 4'h0, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h0, 3'b000, 4'd0}) begin
            errors++; $display("[TB] FAIL clear got %h want %h", status, {1'b1, 11'd0});
        end
        do_op(LD, 4'h5, 1'b1, 1'b0);
        do_op(ADD, 4'h6, 1'b1, 1'b0);
        checks++;
        if (status !== {1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL add_s_wrap got %h want %h", status, {1'b1, 4'hB, 3'b011, 4'd1});
        end
        do_op(LD, 4'h5, 1'b1, 1'b1);
        checks++;
        if (status !== {1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            errors++; $display("[TB] FAIL load_keeps_sticky got %h want %h", status, {1'b1, 4'h5, 3'b001, 4'd0});
        end
        do_op(ADD, 4'h6, 1'b1, 1'b1);
        checks++;
        if (status !== {1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL add_s_sat got %h want %h", status, {1'b1, 4'h7, 3'b011, 4'd1});
        end
    endtask

    task automatic test_sub_unsigned();
        do_op(CLR, 4'h0, 1'b0, 1'b0);
        do_op(LD, 4'h7, 1'b0, 1'b0);
        do_op(SUB, 4'h2, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            errors++; $display("[TB] FAIL sub_u_noborrow got %h want %h", status, {1'b1, 4'h5, 3'b100, 4'd1});
        end
        do_op(LD, 4'h5, 1'b0, 1'b0);
        do_op(SUB, 4'h6, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL sub_u_wrap got %h want %h", status, {1'b1, 4'hF, 3'b011, 4'd1});
        end
        do_op(LD, 4'h5, 1'b0, 1'b1);
        do_op(SUB, 4'h6, 1'b0, 1'b1);
        checks++;
        if (status !== {1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL sub_u_sat got %h want %h", status, {1'b1, 4'h0, 3'b011, 4'd1});
        end
    endtask

    task automatic test_sub_signed();
        do_op(LD, 4'h6, 1'b1, 1'b0);
        do_op(SUB, 4'hD, 1'b1, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL sub_s_wrap got %h want %h", status, {1'b1, 4'h9, 3'b011, 4'd1});
        end
        do_op(LD, 4'h6, 1'b1, 1'b1);
        do_op(SUB, 4'hD, 1'b1, 1'b1);
        checks++;
        if (status !== {1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL sub_s_sat got %h want %h", status, {1'b1, 4'h7, 3'b011, 4'd1});
        end
    endtask

    task automatic test_saturation_bounds();
        do_op(LD, 4'hC, 1'b0, 1'b1);
        do_op(ADD, 4'h6, 1'b0, 1'b1);
        checks++;
        if (status !== {1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL add_u_sat got %h want %h", status, {1'b1, 4'hF, 3'b111, 4'd1});
        end
        do_op(LD, 4'h9, 1'b1, 1'b1);
        do_op(ADD, 4'hC, 1'b1, 1'b1);
        checks++;
        if (status !== {1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 4'd1}) begin
            errors++; $display("[TB] FAIL add_s_negsat got %h want %h", status, {1'b1, 4'h8, 3'b111, 4'd1});
        end
    endtask

    task automatic test_back_to_back();
        do_op(CLR, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = 4'h1; bus.op = ADD;
        bus.is_signed = 1'b0; bus.sat_en = 1'b0;
        @(negedge clk);
        checks++;
        if (status !== 12'h000) begin
            errors++; $display("[TB] FAIL b2b_latency got %h want %h", status, 12'h000);
        end
        @(negedge clk);
        checks++;
        if (status !== {1'b1, 4'h1, 3'b000, 4'd1}) begin
            errors++; $display("[TB] FAIL b2b_first got %h want %h", status, {1'b1, 4'h1, 3'b000, 4'd1});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (status !== {1'b1, 4'h2, 3'b000, 4'd2}) begin
            errors++; $display("[TB] FAIL b2b_second got %h want %h", status, {1'b1, 4'h2, 3'b000, 4'd2});
        end
        @(negedge clk);
        checks++;
        if (status !== {1'b1, 4'h3, 3'b000, 4'd3}) begin
            errors++; $display("[TB] FAIL b2b_third got %h want %h", status, {1'b1, 4'h3, 3'b000, 4'd3});
        end
        @(negedge clk);
        checks++;
        if (status !== {1'b0, 4'h3, 3'b000, 4'd3}) begin
            errors++; $display("[TB] FAIL b2b_idle got %h want %h", status, {1'b0, 4'h3, 3'b000, 4'd3});
        end
    endtask

    task automatic test_sticky();
        do_op(LD, 4'hF, 1'b0, 1'b0);
        do_op(ADD, 4'h1, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h0, 3'b111, 4'd1}) begin
            errors++; $display("[TB] FAIL sticky_set got %h want %h", status, {1'b1, 4'h0, 3'b111, 4'd1});
        end
        do_op(LD, 4'h2, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h2, 3'b001, 4'd0}) begin
            errors++; $display("[TB] FAIL sticky_hold got %h want %h", status, {1'b1, 4'h2, 3'b001, 4'd0});
        end
        do_op(CLR, 4'h0, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h0, 3'b000, 4'd0}) begin
            errors++; $display("[TB] FAIL sticky_clear got %h want %h", status, {1'b1, 11'd0});
        end
    endtask

    task automatic test_op_count_saturation();
        for (int i = 0; i < 15; i++) begin
            do_op(ADD, 4'h0, 1'b0, 1'b0);
        end
        checks++;
        if (status !== {1'b1, 4'h0, 3'b000, 4'hF}) begin
            errors++; $display("[TB] FAIL count_reach_max got %h want %h", status, {1'b1, 4'h0, 3'b000, 4'hF});
        end
        do_op(SUB, 4'h0, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h0, 3'b100, 4'hF}) begin
            errors++; $display("[TB] FAIL count_hold_max got %h want %h", status, {1'b1, 4'h0, 3'b100, 4'hF});
        end
    endtask

    task automatic test_reset_mid_op();
        do_op(LD, 4'hE, 1'b0, 1'b0);
        do_op(ADD, 4'h3, 1'b0, 1'b0);
        checks++;
        if (status !== {1'b1, 4'h1, 3'b111, 4'd1}) begin
            errors++; $display("[TB] FAIL pre_reset got %h want %h", status, {1'b1, 4'h1, 3'b111, 4'd1});
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = 4'h2; bus.op = ADD;
        bus.is_signed = 1'b0; bus.sat_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (status !== 12'h000) begin
            errors++; $display("[TB] FAIL async_reset got %h want %h", status, 12'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (status !== 12'h000) begin
                errors++; $display("[TB] FAIL reset_discard got %h want %h", status, 12'h000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_unsigned();
        test_add_signed();
        test_sub_unsigned();
        test_sub_signed();
        test_saturation_bounds();
        test_back_to_back();
        test_sticky();
        test_op_count_saturation();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator_nbit.md
# addsub_accumulator_nbit

Parametrised, pipelined n-bit add/subtract accumulator with load/clear, signed or unsigned saturation, carry/overflow flags and a sticky overflow flag. It extends the combinational n-bit adder/subtractor (`cntrl` selects add/subtract, with `c_out`/`overflow`) into a registered datapath block. It accepts one operation per cycle through a valid handshake and holds the running result in an internal accumulator. It sits behind operand sources in the datapath and feeds downstream logic through `out_valid`.

## Interface

Parameters:
- `n`, default 4: datapath width in bits (≥ 2).

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request, sampled every rising edge.
- `x`  in  n  operand.
- `op`  in  2  operation code: 00 add, 01 subtract, 10 load, 11 clear.
- `is_signed`  in  1  1 means two's-complement overflow/saturation rules; 0 means unsigned.
- `sat_en`  in  1  1 means saturate on overflow; 0 means wrap.
- `acc`  out  n  accumulator value.
- `out_valid`  out  1  one-cycle pulse when `acc` and the flags reflect a completed operation.
- `c_out`  out  1  carry out of the n-bit adder for the last add/subtract.
- `overflow`  out  1  overflow of the last add/subtract under the selected mode.
- `ovf_sticky`  out  1  set by any overflow; holds until clear or reset.
- `op_count`  out  n  number of add/subtract ops since the last load/clear; saturates at all-ones.

## Operation

- Stage 1 (accept): on a rising edge with `in_valid`=1, register `x`, `op`, `is_signed`, `sat_en` and a stage-1 valid bit. There is no backpressure; every valid request is accepted.
- Stage 2 (execute): when stage-1 valid is set, compute the result from the current `acc` and the registered operand, then write `acc`, the flags and `op_count`, and pulse `out_valid`.
- Adder core: `sum = acc + (op==01 ? ~x : x) + (op==01)`, computed (n+1) bits wide; `c_out = sum[n]`.
- Subtract `c_out` convention: 1 = no borrow, 0 = borrow.
- Signed overflow: `acc[n-1]` equals the effective operand MSB and differs from `sum[n-1]`.
- Unsigned overflow: add with `c_out`=1, or subtract with `c_out`=0.
- `overflow` reports the signed rule when the registered `is_signed`=1, otherwise the unsigned rule.
- Saturation (`sat_en`=1 and `overflow`=1), result written to `acc`:
  - signed: 2^(n-1)-1 if `acc[n-1]`=0, else -2^(n-1) (MSB set, rest zero).
  - unsigned add: all-ones.
  - unsigned subtract: zero.
- Wrap (`sat_en`=0): `acc = sum[n-1:0]`.
- Load: `acc = x`; `c_out`=0, `overflow`=0; `op_count`=0; `ovf_sticky` unchanged.
- Clear: `acc` = 0, `c_out`=0, `overflow`=0, `op_count`=0, `ovf_sticky`=0.
- Add/subtract: `op_count` increments by 1 and holds at 2^n-1. `ovf_sticky` is ORed with `overflow`; the sticky bit follows the flag, and saturation does not suppress it.
- When no operation completes, `acc`, `c_out`, `overflow`, `ovf_sticky` and `op_count` hold their values.

## Timing

- Reset values (asynchronous, immediate): `acc`=0, `out_valid`=0, `c_out`=0, `overflow`=0, `ovf_sticky`=0, `op_count`=0, stage-1 valid=0.
- Latency: a request sampled at edge k produces the updated `acc` and `out_valid`=1 after edge k+1.
- Throughput: one operation per cycle.
- Back-to-back operations: only stage 2 writes `acc`, so each operation uses the result of the previous one with no hazard and no forwarding.
- `out_valid` is high for exactly one cycle per accepted request. It stays high continuously under continuous `in_valid`.
- Reset asserted mid-operation discards the stage-1 contents. No `out_valid` is produced for that request after reset deasserts.
- Mode inputs are sampled together with the operand; changes between requests affect only later requests.

## Test plan

All scenarios use n=4.

- Load 5, then add 6 with `is_signed`=0, `sat_en`=0 → `acc`=4'hB, `c_out`=0, `overflow`=0, `op_count`=1.
- Repeat with `is_signed`=1 → `sat_en`=0 gives `acc`=4'hB, `overflow`=1; `sat_en`=1 gives `acc`=4'h7, `overflow`=1, `ovf_sticky`=1.
- Load 5, subtract 6, unsigned → `sat_en`=0 gives `acc`=4'hF, `c_out`=0, `overflow`=1; `sat_en`=1 gives `acc`=0.
- Load 6, subtract 4'hD (-3), signed → `sat_en`=0 gives `acc`=4'h9, `c_out`=0, `overflow`=1; `sat_en`=1 gives `acc`=4'h7.
- Clear, then `in_valid` held for 3 cycles, add 1 each → `out_valid` high 3 consecutive cycles starting 2 edges after the first request; `acc`=1, 2, 3; `op_count`=3.
- Force an overflow, then load 2 → `ovf_sticky` stays 1, `op_count`=0. Then clear → `ovf_sticky`=0.
- Assert `rst` one cycle after a request is accepted → all outputs go to 0 immediately, and no `out_valid` pulse follows.
